// File: rtl/lfsr_stream_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// lfsr_stream_arbiter
//
// Shares one 16-bit Fibonacci LFSR among NUM_REQ requesters. Requesters are
// granted round-robin. The granted requester receives a burst of 1..16 LFSR
// words over a valid/ready handshake. The LFSR advances only when a word is
// actually transferred. Reseeding is accepted only while idle. A zero seed is
// replaced by 16'hACE1, so the register can never lock up at all-zero.
//
// Parameters
//   NUM_REQ     number of requesters (2..8)
//   RESET_SEED  LFSR value after reset (must be nonzero)
//
// Ports
//   clk         clock, all logic on the rising edge
//   nReset      asynchronous active-low reset
//   seed_load   one-cycle pulse: load 'seed' into the LFSR (idle only)
//   seed        seed value sampled with seed_load
//   req         per-requester request levels
//   len         per-requester burst length, len[4i+3:4i] = words-1
//   out_ready   granted consumer accepts the current word
//   gnt         registered one-hot grant, zero while idle
//   out_valid   out_data carries a word of the current burst
//   out_data    current LFSR state (always visible)
//   out_last    current word is the final word of the burst
//   busy        a burst is in progress (|gnt)
//   seed_drop   one-cycle pulse: a seed_load arrived during a burst and was ignored
// ---------------------------------------------------------------------------
module lfsr_stream_arbiter #(
    parameter int          NUM_REQ    = 4,
    parameter logic [15:0] RESET_SEED = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic                   seed_load,
    input  logic [15:0]            seed,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   len,
    input  logic                   out_ready,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   out_valid,
    output logic [15:0]            out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   seed_drop
);

    localparam int          PW            = $clog2(NUM_REQ);
    localparam int          SW            = PW + 1;
    localparam logic [15:0] FALLBACK_SEED = 16'hACE1;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                seed_drop_q, seed_drop_d;

    logic                win_found;
    logic [PW-1:0]       win_idx;
    logic [SW-1:0]       arb_sum;

    // Taps 16,14,13,11 (bits 15,13,12,10): maximal-length sequence.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Round-robin winner search. The offsets are walked from farthest to
    // nearest, so the last hit (smallest offset from ptr) wins. This gives
    // upward search with wrap, starting at ptr. The sum is one bit wider than
    // ptr so that ptr+offset cannot overflow before the modulo wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        arb_sum   = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            arb_sum = SW'(ptr_q) + SW'(off);
            if (arb_sum >= SW'(NUM_REQ)) begin
                arb_sum = arb_sum - SW'(NUM_REQ);
            end
            if (req[arb_sum[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = arb_sum[PW-1:0];
            end
        end
    end

    // Next-state logic. A seed load and an arbitration win in the same idle
    // cycle both take effect. The first word of that burst is therefore the
    // new seed. In a burst, cnt counts the words still to go after the
    // current one, so the transfer made at cnt==0 ends the burst.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        seed_drop_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (seed_load) begin
                    lfsr_d = (seed == 16'h0000) ? FALLBACK_SEED : seed;
                end
                if (win_found) begin
                    state_d          = BURST;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    cnt_d            = len[{win_idx, 2'b00} +: 4];
                    ptr_d            = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                end
            end

            BURST: begin
                seed_drop_d = seed_load;
                if (out_ready) begin
                    lfsr_d = lfsr_step(lfsr_q);
                    if (cnt_q == 4'd0) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            lfsr_q      <= RESET_SEED;
            cnt_q       <= '0;
            ptr_q       <= '0;
            gnt_q       <= '0;
            seed_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            seed_drop_q <= seed_drop_d;
        end
    end

    // All outputs come straight from registers, so an asynchronous reset
    // clears them at once.
    assign gnt       = gnt_q;
    assign out_valid = (state_q == BURST);
    assign out_data  = lfsr_q;
    assign out_last  = (state_q == BURST) && (cnt_q == 4'd0);
    assign busy      = |gnt_q;
    assign seed_drop = seed_drop_q;

endmodule
